// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command bytes
// and the microsecond-to-clock-cycle conversion used to size timers.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    WAIT_CLK,
    SEND,
    RELEASE,
    DONE,
    ERR
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  function automatic int unsigned us_to_cyc(input int unsigned clk_hz, input int unsigned us);
    return (clk_hz / 1000000) * us;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 pin plus a history flop that yields
// a single-cycle pulse on each falling edge. Idle level of the bus is high.
module ps2_line_sync (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic pin_in,
  output logic level,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic hist_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      hist_reg <= 1'b1;
    end else begin
      meta_reg <= pin_in;
      sync_reg <= meta_reg;
      hist_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign fall  = hist_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts out one byte with odd parity on device clock edges and checks the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned INHIBIT_US  = 120,
  parameter int unsigned REQ_US      = 5,
  parameter int unsigned START_TO_US = 15000,
  parameter int unsigned PKT_TO_US   = 2000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error,
  output logic       rx_inhibit,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_drive_low,
  output logic       ps2data_drive_low
);

  localparam int unsigned INHIBIT_CYC  = us_to_cyc(CLK_HZ, INHIBIT_US);
  localparam int unsigned REQ_CYC      = us_to_cyc(CLK_HZ, REQ_US);
  localparam int unsigned START_TO_CYC = us_to_cyc(CLK_HZ, START_TO_US);
  localparam int unsigned PKT_TO_CYC   = us_to_cyc(CLK_HZ, PKT_TO_US);
  localparam int          CW           = $clog2(START_TO_CYC + 1);

  localparam logic [CW-1:0] INHIBIT_LAST  = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] REQ_LAST      = CW'(REQ_CYC - 1);
  localparam logic [CW-1:0] START_TO_LAST = CW'(START_TO_CYC - 1);
  localparam logic [CW-1:0] PKT_TO_LAST   = CW'(PKT_TO_CYC - 1);

  logic clk_level, clk_fall, data_level, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .pin_in  (ps2clk_in),
    .level   (clk_level),
    .fall    (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .pin_in  (ps2data_in),
    .level   (data_level),
    .fall    (data_fall_unused)
  );

  ps2_state_e    state_reg, state_next;
  logic [CW-1:0] timer_reg, timer_next;
  logic [3:0]    edge_reg, edge_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_reg, parity_next;
  logic          clk_low_reg, clk_low_next;
  logic          data_low_reg, data_low_next;
  logic          ack_reg, ack_next;
  logic          err_reg, err_next;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      edge_reg     <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      clk_low_reg  <= 1'b0;
      data_low_reg <= 1'b0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      edge_reg     <= edge_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      clk_low_reg  <= clk_low_next;
      data_low_reg <= data_low_next;
      ack_reg      <= ack_next;
      err_reg      <= err_next;
    end
  end

  // One timer serves the inhibit/request/start phases, then restarts at
  // edge 1 to bound the whole packet including the release wait.
  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg + CW'(1);
    edge_next     = edge_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    clk_low_next  = clk_low_reg;
    data_low_next = data_low_reg;
    ack_next      = ack_reg;
    err_next      = err_reg;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (tx_start) begin
          shift_next    = tx_data;
          parity_next   = ~^tx_data;
          ack_next      = 1'b0;
          err_next      = 1'b0;
          clk_low_next  = 1'b1;
          data_low_next = 1'b0;
          state_next    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (timer_reg == INHIBIT_LAST) begin
          timer_next    = '0;
          data_low_next = 1'b1;
          state_next    = REQ;
        end
      end
      REQ: begin
        if (timer_reg == REQ_LAST) begin
          timer_next   = '0;
          clk_low_next = 1'b0;
          edge_next    = '0;
          state_next   = WAIT_CLK;
        end
      end
      WAIT_CLK: begin
        if (clk_fall) begin
          data_low_next = ~shift_reg[0];
          shift_next    = shift_reg >> 1;
          edge_next     = 4'd1;
          timer_next    = '0;
          state_next    = SEND;
        end else if (timer_reg == START_TO_LAST) begin
          clk_low_next  = 1'b0;
          data_low_next = 1'b0;
          err_next      = 1'b1;
          state_next    = ERR;
        end
      end
      SEND: begin
        // edge_reg holds the previous edge number; this fall is edge_reg+1.
        if (clk_fall) begin
          edge_next = edge_reg + 4'd1;
          if (edge_reg < 4'd8) begin
            data_low_next = ~shift_reg[0];
            shift_next    = shift_reg >> 1;
          end else if (edge_reg == 4'd8) begin
            data_low_next = ~parity_reg;
          end else if (edge_reg == 4'd9) begin
            data_low_next = 1'b0;
          end else begin
            ack_next   = ~data_level;
            state_next = RELEASE;
          end
        end else if (timer_reg == PKT_TO_LAST) begin
          clk_low_next  = 1'b0;
          data_low_next = 1'b0;
          err_next      = 1'b1;
          state_next    = ERR;
        end
      end
      RELEASE: begin
        if (clk_level && data_level) begin
          state_next = DONE;
        end else if (timer_reg == PKT_TO_LAST) begin
          clk_low_next  = 1'b0;
          data_low_next = 1'b0;
          err_next      = 1'b1;
          state_next    = ERR;
        end
      end
      DONE, ERR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign done              = (state_reg == DONE) || (state_reg == ERR);
  assign busy              = (state_reg != IDLE) && !done;
  assign rx_inhibit        = busy;
  assign ack_ok            = ack_reg;
  assign error             = err_reg;
  assign ps2clk_drive_low  = clk_low_reg;
  assign ps2data_drive_low = data_low_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx at 1 MHz with a 10 kHz behavioural keyboard
// model on open-drain PS2Clk/PS2Data lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned CLK_HZ   = 1000000;
  localparam int          HALF     = 5;
  localparam int          DEV_HALF = 50 * 2 * HALF;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, done, ack_ok, error, rx_inhibit;
  logic       ps2clk_drive_low, ps2data_drive_low;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2clk_line, ps2data_line;

  assign ps2clk_line  = ~(ps2clk_drive_low | dev_clk_low);
  assign ps2data_line = ~(ps2data_drive_low | dev_data_low);

  ps2_host_tx #(.CLK_HZ(CLK_HZ)) dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .tx_data           (tx_data),
    .tx_start          (tx_start),
    .busy              (busy),
    .done              (done),
    .ack_ok            (ack_ok),
    .error             (error),
    .rx_inhibit        (rx_inhibit),
    .ps2clk_in         (ps2clk_line),
    .ps2data_in        (ps2data_line),
    .ps2clk_drive_low  (ps2clk_drive_low),
    .ps2data_drive_low (ps2data_drive_low)
  );

  always #HALF sys_clk = ~sys_clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Cycle counter and line monitor, sampled on the falling clock edge.
  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int          inhib_cnt = 0;
  int          done_cnt = 0;
  int unsigned rel_cyc = 0, send_cyc = 0, done_cyc = 0;
  logic        done_ack = 1'b0, done_err = 1'b0, done_drv = 1'b0;
  logic        prev_clk_low = 1'b0, prev_data_low = 1'b0, armed = 1'b0;

  always @(negedge sys_clk) begin
    if (ps2clk_drive_low && !ps2data_drive_low) inhib_cnt++;
    if (prev_clk_low && !ps2clk_drive_low && ps2data_drive_low) begin
      rel_cyc = cyc;
      armed   = 1'b1;
    end else if (armed && prev_data_low && !ps2data_drive_low) begin
      send_cyc = cyc;
      armed    = 1'b0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_ack = ack_ok;
      done_err = error;
      done_drv = ps2clk_drive_low | ps2data_drive_low;
    end
    prev_clk_low  = ps2clk_drive_low;
    prev_data_low = ps2data_drive_low;
  end

  task automatic start_tx(input logic [7:0] d);
    @(negedge sys_clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge sys_clk);
    tx_start = 1'b0;
  endtask

  // Keyboard model: waits for the request-to-send, then clocks n_edges bits,
  // sampling the data line while the clock is low.
  task automatic dev_frame(input int n_edges, input bit ack_low, output logic [9:0] got);
    int waited = 0;
    got = '1;
    while (!(ps2data_drive_low && !ps2clk_drive_low) && waited < 1000) begin
      @(negedge sys_clk);
      waited++;
    end
    check_eq("dev_request_seen", 32'(waited < 1000), 32'd1);
    for (int n = 1; n <= n_edges; n++) begin
      if (n == 11 && ack_low) dev_data_low = 1'b1;
      #(DEV_HALF);
      dev_clk_low = 1'b1;
      #(DEV_HALF);
      if (n <= 10) got[n-1] = ps2data_line;
      dev_clk_low = 1'b0;
    end
    if (n_edges >= 11) begin
      #(DEV_HALF / 2);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int base, input int max_cyc);
    int waited = 0;
    while (done_cnt == base && waited < max_cyc) begin
      @(posedge sys_clk);
      waited++;
    end
    check_eq(tag, 32'(done_cnt != base), 32'd1);
    repeat (3) @(negedge sys_clk);
  endtask

  initial begin
    logic [9:0] got;
    int base, ib;

    @(negedge sys_clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ack_ok", 32'(ack_ok), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_clk_drive", 32'(ps2clk_drive_low), 32'd0);
    check_eq("rst_data_drive", 32'(ps2data_drive_low), 32'd0);
    check_eq("rst_rx_inhibit", 32'(rx_inhibit), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);

    // 1: 0xED with ACK
    base = done_cnt;
    ib   = inhib_cnt;
    start_tx(CMD_SET_LEDS);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_rx_inhibit", 32'(rx_inhibit), 32'd1);
    dev_frame(11, 1'b1, got);
    wait_done("t1_done_seen", base, 500);
    $display("[TB] tx=ED bits=%b ack=%0d err=%0d", got, done_ack, done_err);
    check_eq("t1_bits", 32'(got), 32'h3ED);
    check_eq("t1_inhibit_cycles", 32'(inhib_cnt - ib), 32'd120);
    check_eq("t1_ack", 32'(done_ack), 32'd1);
    check_eq("t1_err", 32'(done_err), 32'd0);
    check_eq("t1_done_count", 32'(done_cnt - base), 32'd1);
    check_eq("t1_busy_after", 32'(busy), 32'd0);

    // 2: 0xF4 with NACK, parity 0
    base = done_cnt;
    start_tx(8'hF4);
    dev_frame(11, 1'b0, got);
    wait_done("t2_done_seen", base, 500);
    $display("[TB] tx=F4 bits=%b ack=%0d err=%0d", got, done_ack, done_err);
    check_eq("t2_bits", 32'(got), 32'h2F4);
    check_eq("t2_ack", 32'(done_ack), 32'd0);
    check_eq("t2_err", 32'(done_err), 32'd0);

    // 3: device never clocks
    base = done_cnt;
    start_tx(CMD_ECHO);
    wait_done("t3_done_seen", base, 16000);
    $display("[TB] tx=EE no device clock, done %0d cycles after release err=%0d",
             done_cyc - rel_cyc, done_err);
    check_eq("t3_start_timeout_cycles", done_cyc - rel_cyc, 32'd15000);
    check_eq("t3_err", 32'(done_err), 32'd1);
    check_eq("t3_ack", 32'(done_ack), 32'd0);
    check_eq("t3_drives_released", 32'(done_drv), 32'd0);

    // 4: device stops after 5 edges
    base = done_cnt;
    start_tx(CMD_SET_LEDS);
    dev_frame(5, 1'b0, got);
    wait_done("t4_done_seen", base, 2500);
    $display("[TB] tx=ED 5 edges, done %0d cycles after edge 1 err=%0d",
             done_cyc - send_cyc, done_err);
    check_eq("t4_first_bits", 32'(got[4:0]), 32'h0D);
    check_eq("t4_pkt_timeout_cycles", done_cyc - send_cyc, 32'd2000);
    check_eq("t4_err", 32'(done_err), 32'd1);
    check_eq("t4_drives_released", 32'(done_drv), 32'd0);

    // 5a: second request during a 0xFF transfer is ignored
    base = done_cnt;
    start_tx(CMD_RESET);
    repeat (10) @(negedge sys_clk);
    start_tx(8'h00);
    dev_frame(11, 1'b1, got);
    wait_done("t5_done_seen", base, 500);
    $display("[TB] tx=FF with ignored 00, bits=%b ack=%0d err=%0d", got, done_ack, done_err);
    check_eq("t5_bits", 32'(got), 32'h3FF);
    check_eq("t5_ack", 32'(done_ack), 32'd1);
    repeat (200) @(negedge sys_clk);
    check_eq("t5_no_queue_busy", 32'(busy), 32'd0);
    check_eq("t5_done_count", 32'(done_cnt - base), 32'd1);

    // 5b: reset during SEND
    base = done_cnt;
    start_tx(8'h00);
    dev_frame(4, 1'b0, got);
    repeat (10) @(negedge sys_clk);
    check_eq("t5b_busy_before", 32'(busy), 32'd1);
    check_eq("t5b_data_drive_before", 32'(ps2data_drive_low), 32'd1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_eq("t5b_clk_drive", 32'(ps2clk_drive_low), 32'd0);
    check_eq("t5b_data_drive", 32'(ps2data_drive_low), 32'd0);
    check_eq("t5b_busy", 32'(busy), 32'd0);
    sys_rst = 1'b0;
    repeat (300) @(negedge sys_clk);
    $display("[TB] tx=00 reset in SEND, done pulses=%0d", done_cnt - base);
    check_eq("t5b_no_done", 32'(done_cnt - base), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
